img_stream_tx: RTL and testbench
================================

# img_stream_tx

Video-stream transmitter that turns a valid/ready pixel source (frame buffer reader, DMA, pattern ROM) into the frame protocol consumed by the image-processing cores: per_img_vsync frames the picture, per_img_href qualifies each 8-bit gray pixel, and blanking separates rows. It is the hardware counterpart of the bench-side frame driver. It sits at the head of every processing chain (e.g. in front of bilateral_filter_proc).

## Interface
- IMG_HDISP, 640, active pixels per row (≥1)
- IMG_VDISP, 480, active rows per frame (≥1)
- V_PRE, 5, cycles of vsync high before the first href of a frame (≥1)
- H_BLANK, 10, href-low cycles between consecutive rows (≥1)
- V_POST, 5, cycles of vsync high after the last href of a frame (≥1)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  single-cycle request to send one frame; honoured only in IDLE
- s_valid  in  1  source pixel valid
- s_ready  out  1  block accepts pixel this cycle
- s_data  in  8  source gray pixel, raster order
- busy  out  1  frame in progress (state ≠ IDLE)
- post_img_vsync  out  1  frame valid
- post_img_href  out  1  pixel valid
- post_img_gray  out  8  pixel value
- underflow_cnt  out  16  count of ACTIVE cycles with s_valid low

## Operation
- FSM states: IDLE, VPRE, ACTIVE, HBLANK, VPOST.
- IDLE: s_ready=0; frame_start=1 → VPRE, clear row/col counters. frame_start in any other state ignored.
- VPRE: count V_PRE cycles → ACTIVE.
- ACTIVE: s_ready=1. Transfer = s_valid & s_ready; each transfer increments col. On the IMG_HDISP-th transfer: if row = IMG_VDISP-1 → VPOST, else row++, col=0 → HBLANK. s_valid low in ACTIVE = underflow: no href that cycle, state holds (href gaps are legal; downstream qualifies by href).
- HBLANK: count H_BLANK cycles → ACTIVE.
- VPOST: count V_POST cycles → IDLE.
- Counters: col/row width $clog2(IMG_HDISP)/$clog2(IMG_VDISP) (min 1); blank counter sized for max(V_PRE,H_BLANK,V_POST).
- underflow_cnt saturates at 16'hFFFF; cleared by reset and at frame_start acceptance.

## Timing
- All outputs registered. post_img_vsync = registered (state ≠ IDLE); post_img_href = registered transfer; post_img_gray = registered s_data on transfer, holds last value otherwise.
- frame_start sampled at edge N → state VPRE from edge N+1 → post_img_vsync high from edge N+2.
- vsync high exactly V_PRE cycles before first href; href low exactly H_BLANK cycles between rows (no underflow); vsync high exactly V_POST cycles after last href; then low ≥1 cycle before next frame can start (frame_start earliest accepted in the first IDLE cycle).
- Pixel latency: s_data accepted at edge N appears on post_img_gray with href at edge N+1.
- Reset: post_img_vsync=0, post_img_href=0, post_img_gray=0, s_ready=0, busy=0, underflow_cnt=0, state IDLE. Reset mid-frame aborts immediately; no partial vsync tail.
- frame_start and rst_n low in same cycle: reset wins.

## Configuration
- IMG_STREAM_TX_UNDERFLOW_EN defined: underflow_cnt implemented as above.
- Not defined: no counter logic; underflow_cnt tied to 16'h0000. Stream behaviour otherwise identical.

## Test plan
- IMG_HDISP=4, IMG_VDISP=2, V_PRE=3, H_BLANK=2, V_POST=3, s_valid always 1, data 8'h10..8'h17 → vsync high 16 consecutive cycles; href pattern 3 low, 4 high (10,11,12,13), 2 low, 4 high (14..17), 3 low; vsync then falls.
- Same config, s_valid low for one cycle after 2nd pixel of row 0 → one-cycle href gap inside row 0, vsync high 17 cycles, underflow_cnt=1 (0 without macro), all 8 pixels in order.
- frame_start pulsed again mid-frame → ignored; exactly one frame emitted; busy falls with state IDLE.
- rst_n low for one cycle during row 1 → next edge vsync=href=0, gray=0, busy=0; new frame_start produces complete clean frame.
- Back-to-back: frame_start in first IDLE cycle after frame 1 → vsync low exactly 2 cycles between frames, frame 2 identical in timing.
- Default 640×480 with ramp source → bench checker sees 307200 hrefs, 480 rows, every pixel matches source order.

Source files
------------

// File: rtl/img_stream_tx_if.sv
// Pixel source handshake plus the outgoing vsync/href/gray frame stream.
interface img_stream_tx_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       post_img_vsync;
    logic       post_img_href;
    logic [7:0] post_img_gray;

    // Pixel source side: supplies pixels and observes the stream.
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  post_img_vsync,
        input  post_img_href,
        input  post_img_gray
    );

    // Transmitter side: accepts pixels and produces the stream.
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output post_img_vsync,
        output post_img_href,
        output post_img_gray
    );
endinterface

// File: rtl/img_stream_tx.sv
// img_stream_tx: turns a valid/ready gray pixel source into a vsync/href frame
// stream with vsync pre/post guard time and horizontal blanking between rows.
// Optional macro IMG_STREAM_TX_UNDERFLOW_EN enables the source-underflow counter;
// without it underflow_cnt is tied to zero.
module img_stream_tx #(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480,
    parameter int unsigned V_PRE     = 5,
    parameter int unsigned H_BLANK   = 10,
    parameter int unsigned V_POST    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    img_stream_tx_if.slave    vif,
    output logic              busy,
    output logic [15:0]       underflow_cnt
);

    localparam int unsigned COL_W   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int unsigned ROW_W   = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam int unsigned BLK_MX0 = (V_PRE > H_BLANK) ? V_PRE : H_BLANK;
    localparam int unsigned BLK_MAX = (BLK_MX0 > V_POST) ? BLK_MX0 : V_POST;
    localparam int unsigned BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VPRE   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        VPOST  = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [COL_W-1:0]   col, col_nx;
    logic [ROW_W-1:0]   row, row_nx;
    logic [BLK_W-1:0]   blk, blk_nx;
    logic               start_q;
    logic               xfer_c;

    assign xfer_c = vif.s_valid & vif.s_ready;

    // State and position counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            blk   <= '0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            row   <= row_nx;
            blk   <= blk_nx;
        end
    end

    // Next-state logic; blank counter is loaded with length-1 and counts down to 0.
    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        blk_nx   = blk;
        case (state)
            IDLE: begin
                if (start_q) begin
                    state_nx = VPRE;
                    col_nx   = '0;
                    row_nx   = '0;
                    blk_nx   = BLK_W'(V_PRE - 1);
                end
            end
            VPRE: begin
                if (blk == '0) state_nx = ACTIVE;
                else           blk_nx   = blk - 1'b1;
            end
            ACTIVE: begin
                if (xfer_c) begin
                    if (col == COL_W'(IMG_HDISP - 1)) begin
                        col_nx = '0;
                        if (row == ROW_W'(IMG_VDISP - 1)) begin
                            state_nx = VPOST;
                            blk_nx   = BLK_W'(V_POST - 1);
                        end else begin
                            row_nx   = row + 1'b1;
                            state_nx = HBLANK;
                            blk_nx   = BLK_W'(H_BLANK - 1);
                        end
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            HBLANK: begin
                if (blk == '0) state_nx = ACTIVE;
                else           blk_nx   = blk - 1'b1;
            end
            VPOST: begin
                if (blk == '0) state_nx = IDLE;
                else           blk_nx   = blk - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs; frame_start is only captured while idle so mid-frame pulses vanish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q            <= 1'b0;
            vif.s_ready        <= 1'b0;
            busy               <= 1'b0;
            vif.post_img_vsync <= 1'b0;
            vif.post_img_href  <= 1'b0;
            vif.post_img_gray  <= 8'h00;
        end else begin
            start_q            <= frame_start & (state == IDLE);
            vif.s_ready        <= (state_nx == ACTIVE);
            busy               <= (state_nx != IDLE);
            vif.post_img_vsync <= (state != IDLE);
            vif.post_img_href  <= xfer_c;
            if (xfer_c) vif.post_img_gray <= vif.s_data;
        end
    end

`ifdef IMG_STREAM_TX_UNDERFLOW_EN
    // Saturating count of ACTIVE cycles the source had no pixel; restarts per frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow_cnt <= 16'h0000;
        end else if ((state == IDLE) && start_q) begin
            underflow_cnt <= 16'h0000;
        end else if ((state == ACTIVE) && !vif.s_valid && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'h0001;
        end
    end
`else
    assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_img_stream_tx.sv
// Bench for img_stream_tx: small frame geometry, directed and random pixel
// sources, expected stream built cycle by cycle from the frame rules.
module tb_img_stream_tx;

    localparam int unsigned HD   = 4;
    localparam int unsigned VD   = 2;
    localparam int unsigned VP   = 3;
    localparam int unsigned HB   = 2;
    localparam int unsigned VQ   = 3;
    localparam int unsigned NPIX = HD * VD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        busy;
    logic [15:0] underflow_cnt;

    img_stream_tx_if vif ();

    img_stream_tx #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .V_PRE     (VP),
        .H_BLANK   (HB),
        .V_POST    (VQ)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .vif           (vif),
        .busy          (busy),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  pix [NPIX];
    int          g [NPIX];
    logic [7:0]  last_gray = 8'h00;
    bit          exp_v [$];
    bit          exp_h [$];
    logic [7:0]  exp_g [$];
    int          idx;
    int          gap_left;
    bit          last_offer;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit v, input bit h, input logic [7:0] gr);
        exp_v.push_back(v);
        exp_h.push_back(h);
        exp_g.push_back(gr);
    endtask

    // Expected per-cycle stream: 2 idle samples (start capture), V_PRE guard,
    // rows with source gaps and blanking, V_POST guard, one trailing idle sample.
    task automatic build_model();
        logic [7:0] lg;
        lg = last_gray;
        exp_v.delete(); exp_h.delete(); exp_g.delete();
        push(0, 0, lg); push(0, 0, lg);
        repeat (VP) push(1, 0, lg);
        for (int i = 0; i < int'(NPIX); i++) begin
            repeat (g[i]) push(1, 0, lg);
            lg = pix[i];
            push(1, 1, lg);
            if ((i % int'(HD)) == int'(HD) - 1 && i != int'(NPIX) - 1)
                repeat (HB) push(1, 0, lg);
        end
        repeat (VQ) push(1, 0, lg);
        push(0, 0, lg);
    endtask

    function automatic int uf_expected();
        int s;
        s = 0;
`ifdef IMG_STREAM_TX_UNDERFLOW_EN
        foreach (g[i]) s += g[i];
`endif
        return s;
    endfunction

    // Pixel source: withholds pixel idx for g[idx] ready cycles, random noise when not ready.
    task automatic src_step();
        if (last_offer) begin
            idx++;
            gap_left = (idx < int'(NPIX)) ? g[idx] : 0;
        end
        if (vif.s_ready && idx < int'(NPIX)) begin
            if (gap_left > 0) begin
                vif.s_valid = 1'b0;
                gap_left--;
            end else begin
                vif.s_valid = 1'b1;
                vif.s_data  = pix[idx];
            end
        end else begin
            vif.s_valid = 1'($urandom_range(0, 1));
            vif.s_data  = 8'($urandom);
        end
        last_offer = vif.s_ready && vif.s_valid;
    endtask

    task automatic run_frame(input bit pre_started, input int mid_at, input int abort_at, input bit chain);
        int n;
        build_model();
        idx = 0; gap_left = g[0]; last_offer = 1'b0;
        if (!pre_started) begin
            @(negedge clk);
            frame_start = 1'b1;
            src_step();
        end
        n = exp_v.size();
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            frame_start = (j == mid_at);
            chk($sformatf("vsync[%0d]", j), 16'(vif.post_img_vsync), 16'(exp_v[j]));
            chk($sformatf("href[%0d]", j),  16'(vif.post_img_href),  16'(exp_h[j]));
            chk($sformatf("gray[%0d]", j),  16'(vif.post_img_gray),  16'(exp_g[j]));
            chk($sformatf("busy[%0d]", j),  16'(busy), (j + 1 < n) ? 16'(exp_v[j+1]) : 16'h0);
            if (j == abort_at) begin
                rst_n = 1'b0;
                src_step();
                return;
            end
            if (chain && j == n - 2) begin
                chk("underflow_cnt", underflow_cnt, 16'(uf_expected()));
                last_gray = exp_g[n-1];
                frame_start = 1'b1;
                src_step();
                return;
            end
            src_step();
        end
        chk("underflow_cnt", underflow_cnt, 16'(uf_expected()));
        last_gray = exp_g[n-1];
    endtask

    task automatic set_ramp(input logic [7:0] base);
        for (int i = 0; i < int'(NPIX); i++) begin
            pix[i] = base + 8'(i);
            g[i]   = 0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vsync"}, 16'(vif.post_img_vsync), 16'h0);
        chk({tag, "_href"},  16'(vif.post_img_href),  16'h0);
        chk({tag, "_gray"},  16'(vif.post_img_gray),  16'h0);
        chk({tag, "_busy"},  16'(busy),               16'h0);
        chk({tag, "_ready"}, 16'(vif.s_ready),        16'h0);
        chk({tag, "_uf"},    underflow_cnt,           16'h0);
    endtask

    initial begin
        vif.s_valid = 1'b0;
        vif.s_data  = 8'h00;

        // Reset state, with a frame_start that reset must override.
        repeat (3) @(negedge clk);
        chk_idle("reset");
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_wins_busy",  16'(busy),               16'h0);
        chk("reset_wins_vsync", 16'(vif.post_img_vsync), 16'h0);

        // Continuous source, pixels 10..17.
        set_ramp(8'h10);
        run_frame(1'b0, -1, -1, 1'b0);

        // One underflow cycle after the second pixel of row 0.
        set_ramp(8'h10);
        g[2] = 1;
        run_frame(1'b0, -1, -1, 1'b0);

        // frame_start pulsed mid-frame must be ignored.
        set_ramp(8'h20);
        run_frame(1'b0, 6, -1, 1'b0);

        // Reset during row 1, then a clean frame.
        set_ramp(8'h30);
        run_frame(1'b0, -1, 2 + int'(VP + HD + HB) + 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vif.s_valid = 1'b0;
        chk_idle("abort");
        last_gray = 8'h00;
        @(negedge clk);
        chk("abort_no_tail", 16'(vif.post_img_vsync), 16'h0);
        set_ramp(8'h40);
        run_frame(1'b0, -1, -1, 1'b0);

        // Back-to-back frames: start in the first idle cycle.
        set_ramp(8'h50);
        run_frame(1'b0, -1, -1, 1'b1);
        set_ramp(8'h60);
        run_frame(1'b1, -1, -1, 1'b0);

        // Random pixels and random source stalls; last two frames chained.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < int'(NPIX); i++) begin
                pix[i] = 8'($urandom);
                g[i]   = int'($urandom_range(0, 2));
            end
            run_frame(f == 3, -1, -1, f == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
